// File: rtl/mem_stage_pkg.sv
// mem_stage_pkg: shared encodings for the MEM stage (ctrl bits, access types, sizes, FSM states).
package mem_stage_pkg;

    localparam int MC_READ  = 0;
    localparam int MC_WRITE = 1;

    localparam logic [2:0] T_BYTE_S = 3'b000;
    localparam logic [2:0] T_BYTE_U = 3'b001;
    localparam logic [2:0] T_HALF_S = 3'b010;
    localparam logic [2:0] T_HALF_U = 3'b011;
    localparam logic [2:0] T_WORD   = 3'b100;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_t;

    function automatic logic misaligned(logic [2:0] t, logic [1:0] a);
        return t[2] ? |a : (t[1] ? a[0] : 1'b0);
    endfunction

endpackage

// File: rtl/mem_align.sv
// mem_align: store size/strobe/lane replication and load lane select + extension.
module mem_align
    import mem_stage_pkg::*;
(
    input  logic [2:0]  i_type,
    input  logic [1:0]  i_addr,
    input  logic        i_wr,
    input  logic [31:0] i_wdata,
    input  logic [31:0] i_rdata,
    output logic [1:0]  o_size,
    output logic [3:0]  o_wstrb,
    output logic [31:0] o_wdata,
    output logic [31:0] o_rdata
);

    logic        w_word, w_half, w_signed;
    logic [3:0]  w_strb;
    logic [31:0] w_shift;
    logic [7:0]  w_byte;
    logic [15:0] w_hw;

    assign w_word   = i_type[2];
    assign w_half   = ~w_word & i_type[1];
    assign w_signed = (i_type == T_BYTE_S) | (i_type == T_HALF_S);

    assign o_size  = w_word ? SZ_WORD : (w_half ? SZ_HALF : SZ_BYTE);
    assign w_strb  = w_word ? 4'hF : (w_half ? (i_addr[1] ? 4'hC : 4'h3) : 4'b0001 << i_addr);
    assign o_wstrb = i_wr ? w_strb : 4'h0;
    assign o_wdata = w_word ? i_wdata : (w_half ? {2{i_wdata[15:0]}} : {4{i_wdata[7:0]}});

    assign w_shift = i_rdata >> {i_addr, 3'b000};
    assign w_byte  = w_shift[7:0];
    assign w_hw    = i_addr[1] ? i_rdata[31:16] : i_rdata[15:0];
    assign o_rdata = w_word ? i_rdata :
                     (w_half ? {{16{w_signed & w_hw[15]}}, w_hw} : {{24{w_signed & w_byte[7]}}, w_byte});

endmodule

// File: rtl/mem_stage.sv
// mem_stage: MIPS MEM stage; latches EX results, runs the req/addr_ok/data_ok data bus,
// aligns load data and hands the retiring instruction to WB.
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int DW    = 32,
    parameter int CTRLW = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             es_valid_i,
    output logic             ms_allowin_o,
    input  logic [DW-1:0]    pc_i,
    input  logic [DW-1:0]    inst_i,
    input  logic [4:0]       mem_ctrl_i,
    input  logic [CTRLW-1:0] wb_ctrl_i,
    input  logic [DW-1:0]    ALUOut_i,
    input  logic [DW-1:0]    wdata_i,
    input  logic [4:0]       db_dest_i,
    output logic             data_req_o,
    output logic             data_wr_o,
    output logic [1:0]       data_size_o,
    output logic [DW-1:0]    data_addr_o,
    output logic [3:0]       data_wstrb_o,
    output logic [DW-1:0]    data_wdata_o,
    input  logic             data_addr_ok_i,
    input  logic             data_data_ok_i,
    input  logic [DW-1:0]    data_rdata_i,
    output logic [DW-1:0]    pc_o,
    output logic [DW-1:0]    inst_o,
    output logic [CTRLW-1:0] wb_ctrl_o,
    output logic [DW-1:0]    rdata_o,
    output logic [DW-1:0]    ALUOut_o,
    output logic [4:0]       db_dest_o,
    output logic             addr_err_o
);

    state_t           r_state, w_next;
    logic             r_valid;
    logic [DW-1:0]    r_pc, r_inst, r_alu, r_wdata, r_rdata;
    logic [4:0]       r_mc, r_dest;
    logic [CTRLW-1:0] r_wbc;
    logic             w_mem, w_mis, w_done, w_latch, w_in_mem, w_in_mis;

    assign w_mem    = r_mc[MC_READ] | r_mc[MC_WRITE];
    assign w_mis    = w_mem & misaligned(r_mc[4:2], r_alu[1:0]);
    assign w_done   = (r_valid & ~w_mem) | (r_state == S_DONE);
    assign w_latch  = es_valid_i & ms_allowin_o;
    assign w_in_mem = mem_ctrl_i[MC_READ] | mem_ctrl_i[MC_WRITE];
    assign w_in_mis = misaligned(mem_ctrl_i[4:2], ALUOut_i[1:0]);

    assign ms_allowin_o = ~r_valid | w_done;

    // A latching edge decides the new instruction's path even if the old one is retiring.
    always_comb begin
        w_next = r_state;
        if (w_latch)
            w_next = w_in_mem ? (w_in_mis ? S_DONE : S_REQ) : S_IDLE;
        else if (r_state == S_REQ)
            w_next = data_addr_ok_i ? S_WAIT : S_REQ;
        else if (r_state == S_WAIT)
            w_next = data_data_ok_i ? S_DONE : S_WAIT;
        else if (r_state == S_DONE)
            w_next = S_IDLE;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_valid <= 1'b0;
            r_pc    <= '0;
            r_inst  <= '0;
            r_mc    <= '0;
            r_wbc   <= '0;
            r_alu   <= '0;
            r_wdata <= '0;
            r_dest  <= '0;
            r_rdata <= '0;
        end else begin
            r_state <= w_next;
            r_valid <= w_latch | (r_valid & ~w_done);
            if (w_latch) begin
                r_pc    <= pc_i;
                r_inst  <= inst_i;
                r_mc    <= mem_ctrl_i;
                r_wbc   <= wb_ctrl_i;
                r_alu   <= ALUOut_i;
                r_wdata <= wdata_i;
                r_dest  <= db_dest_i;
            end
            if (r_state == S_WAIT && data_data_ok_i)
                r_rdata <= data_rdata_i;
        end
    end

    mem_align u_align (
        .i_type  (r_mc[4:2]),
        .i_addr  (r_alu[1:0]),
        .i_wr    (r_mc[MC_WRITE]),
        .i_wdata (r_wdata),
        .i_rdata (r_rdata),
        .o_size  (data_size_o),
        .o_wstrb (data_wstrb_o),
        .o_wdata (data_wdata_o),
        .o_rdata (rdata_o)
    );

    assign data_req_o  = r_state == S_REQ;
    assign data_wr_o   = r_mc[MC_WRITE];
    assign data_addr_o = r_alu;

    assign pc_o       = r_pc;
    assign inst_o     = r_inst;
    assign ALUOut_o   = r_alu;
    assign db_dest_o  = r_dest;
    assign wb_ctrl_o  = (w_done & ~w_mis) ? r_wbc : '0;
    assign addr_err_o = (r_state == S_DONE) & w_mis;

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: randomized transactions against a transaction-level model of the MEM stage.
module tb_mem_stage;

    logic        clk = 1'b0, reset = 1'b1;
    logic        es_valid_i = 1'b0, ms_allowin_o;
    logic [31:0] pc_i = '0, inst_i = '0, ALUOut_i = '0, wdata_i = '0;
    logic [4:0]  mem_ctrl_i = '0, db_dest_i = '0;
    logic [9:0]  wb_ctrl_i = '0;
    logic        data_req_o, data_wr_o;
    logic [1:0]  data_size_o;
    logic [31:0] data_addr_o, data_wdata_o;
    logic [3:0]  data_wstrb_o;
    logic        data_addr_ok_i = 1'b0, data_data_ok_i = 1'b0;
    logic [31:0] data_rdata_i = '0;
    logic [31:0] pc_o, inst_o, rdata_o, ALUOut_o;
    logic [9:0]  wb_ctrl_o;
    logic [4:0]  db_dest_o;
    logic        addr_err_o;

    int n_chk = 0, n_pass = 0;
    logic [31:0] q_pc, q_alu;
    logic [9:0]  q_wbc;

    mem_stage dut (
        .clk(clk), .reset(reset), .es_valid_i(es_valid_i), .ms_allowin_o(ms_allowin_o),
        .pc_i(pc_i), .inst_i(inst_i), .mem_ctrl_i(mem_ctrl_i), .wb_ctrl_i(wb_ctrl_i),
        .ALUOut_i(ALUOut_i), .wdata_i(wdata_i), .db_dest_i(db_dest_i),
        .data_req_o(data_req_o), .data_wr_o(data_wr_o), .data_size_o(data_size_o),
        .data_addr_o(data_addr_o), .data_wstrb_o(data_wstrb_o), .data_wdata_o(data_wdata_o),
        .data_addr_ok_i(data_addr_ok_i), .data_data_ok_i(data_data_ok_i), .data_rdata_i(data_rdata_i),
        .pc_o(pc_o), .inst_o(inst_o), .wb_ctrl_o(wb_ctrl_o), .rdata_o(rdata_o),
        .ALUOut_o(ALUOut_o), .db_dest_o(db_dest_o), .addr_err_o(addr_err_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    function automatic int nbytes(input logic [2:0] t);
        return t == 3'd4 ? 4 : (t >= 3'd2 ? 2 : 1);
    endfunction

    function automatic bit mis_m(input logic [2:0] t, input logic [31:0] a);
        return (a % nbytes(t)) != 0;
    endfunction

    function automatic logic [31:0] ld_m(input logic [2:0] t, input logic [31:0] a, input logic [31:0] raw);
        logic [31:0] v;
        int nb = nbytes(t);
        if (nb == 4) return raw;
        v = raw >> (8 * (a % 4));
        if (nb == 1) begin
            v = v & 32'hFF;
            if (t == 3'd0 && v >= 128) v = v + 32'hFFFFFF00;
        end else begin
            v = v & 32'hFFFF;
            if (t == 3'd2 && v >= 32768) v = v + 32'hFFFF0000;
        end
        return v;
    endfunction

    function automatic logic [31:0] strb_m(input logic [2:0] t, input logic [31:0] a);
        int nb = nbytes(t);
        return nb == 4 ? 32'hF : (((1 << nb) - 1) << (a % 4));
    endfunction

    function automatic logic [31:0] wd_m(input logic [2:0] t, input logic [31:0] wd);
        int nb = nbytes(t);
        return nb == 1 ? (wd & 32'hFF) * 32'h01010101 : (nb == 2 ? (wd & 32'hFFFF) * 32'h00010001 : wd);
    endfunction

    task automatic run(input logic [31:0] pc, input logic [4:0] mc, input logic [9:0] wbc,
                       input logic [31:0] alu, input logic [31:0] wd, input logic [4:0] dest,
                       input logic [31:0] raw, input int alat, input int dlat, input bit b2b);
        bit load, store, mem, mis, retired, acc;
        int n, rc, wc, lat;
        logic [2:0] t;
        t = mc[4:2];
        load = mc[0];
        store = mc[1];
        mem = load | store;
        mis = mem && mis_m(t, alu);
        @(negedge clk);
        check("idle_wb", {22'd0, wb_ctrl_o}, 32'd0);
        check("idle_err", {31'd0, addr_err_o}, 32'd0);
        check("idle_allow", {31'd0, ms_allowin_o}, 32'd1);
        check("idle_req", {31'd0, data_req_o}, 32'd0);
        pc_i = pc; inst_i = $urandom; mem_ctrl_i = mc; wb_ctrl_i = wbc;
        ALUOut_i = alu; wdata_i = wd; db_dest_i = dest; es_valid_i = 1'b1;
        @(negedge clk);
        if (b2b) begin
            q_pc = $urandom; q_alu = $urandom; q_wbc = 10'($urandom) | 10'd1;
            pc_i = q_pc; ALUOut_i = q_alu; wb_ctrl_i = q_wbc; mem_ctrl_i = 5'd0;
        end else es_valid_i = 1'b0;
        retired = 0; acc = 0; rc = 0; wc = 0; n = 0; lat = -1;
        while (n < 40 && !retired) begin
            if (n > 0) @(negedge clk);
            data_addr_ok_i = 1'b0; data_data_ok_i = 1'b0; data_rdata_i = $urandom;
            if (wb_ctrl_o != 0 || addr_err_o) begin
                retired = 1;
                lat = n;
                check("ret_lat", lat, (mem && !mis) ? alat + dlat + 1 : 0);
                check("ret_wb", {22'd0, wb_ctrl_o}, mis ? 32'd0 : {22'd0, wbc});
                check("ret_err", {31'd0, addr_err_o}, {31'd0, mis});
                check("ret_pc", pc_o, pc);
                check("ret_alu", ALUOut_o, alu);
                check("ret_dest", {27'd0, db_dest_o}, {27'd0, dest});
                check("ret_allow", {31'd0, ms_allowin_o}, 32'd1);
                check("ret_req", {31'd0, data_req_o}, 32'd0);
                check("req_cycles", rc, (mem && !mis) ? alat + 1 : 0);
                if (load && !mis) check("ret_rdata", rdata_o, ld_m(t, alu, raw));
            end else begin
                check("busy_wb", {22'd0, wb_ctrl_o}, 32'd0);
                check("busy_allow", {31'd0, ms_allowin_o}, 32'd0);
                if (data_req_o) begin
                    check("bus_addr", data_addr_o, alu);
                    check("bus_wr", {31'd0, data_wr_o}, {31'd0, store});
                    check("bus_size", {30'd0, data_size_o}, nbytes(t) == 4 ? 2 : nbytes(t) - 1);
                    check("bus_wstrb", {28'd0, data_wstrb_o}, store ? strb_m(t, alu) : 32'd0);
                    if (store) check("bus_wdata", data_wdata_o, wd_m(t, wd));
                    if (rc == alat) begin
                        data_addr_ok_i = 1'b1;
                        acc = 1;
                    end else data_data_ok_i = 1'($urandom);
                    rc++;
                end else if (acc) begin
                    if (wc == dlat - 1) begin
                        data_data_ok_i = 1'b1;
                        data_rdata_i = raw;
                    end
                    wc++;
                end
            end
            n++;
        end
        if (!retired) check("timeout", 32'd0, 32'd1);
        if (b2b) begin
            @(negedge clk);
            es_valid_i = 1'b0;
            check("b2b_wb", {22'd0, wb_ctrl_o}, {22'd0, q_wbc});
            check("b2b_pc", pc_o, q_pc);
            check("b2b_alu", ALUOut_o, q_alu);
        end
    endtask

    initial begin
        #1;
        check("rst_req", {31'd0, data_req_o}, 32'd0);
        check("rst_wb", {22'd0, wb_ctrl_o}, 32'd0);
        check("rst_err", {31'd0, addr_err_o}, 32'd0);
        check("rst_allow", {31'd0, ms_allowin_o}, 32'd1);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;

        run(32'hBFC00000, 5'b000_00, 10'h001, 32'h1234, 32'h0, 5'd3, 32'h0, 0, 1, 0);
        run(32'hBFC00004, 5'b000_01, 10'h003, 32'h1003, 32'h0, 5'd4, 32'h80FF1234, 0, 2, 0);
        run(32'hBFC00008, 5'b011_01, 10'h003, 32'h2002, 32'h0, 5'd5, 32'h80FF1234, 1, 1, 0);
        run(32'hBFC0000C, 5'b000_10, 10'h001, 32'h3001, 32'hAB, 5'd0, 32'h0, 0, 1, 0);
        run(32'hBFC00010, 5'b100_10, 10'h001, 32'h4000, 32'hCAFEF00D, 5'd0, 32'h0, 4, 1, 1);
        run(32'hBFC00014, 5'b100_01, 10'h003, 32'h5002, 32'h0, 5'd6, 32'h0, 0, 1, 0);
        run(32'hBFC00018, 5'b100_01, 10'h003, 32'h6000, 32'h0, 5'd7, 32'h11223344, 0, 1, 1);

        @(negedge clk);
        pc_i = 32'h100; mem_ctrl_i = 5'b100_01; wb_ctrl_i = 10'h3; ALUOut_i = 32'h7000; es_valid_i = 1'b1;
        @(negedge clk);
        es_valid_i = 1'b0;
        data_addr_ok_i = 1'b1;
        @(negedge clk);
        data_addr_ok_i = 1'b0;
        reset = 1'b1;
        #1;
        check("wrst_req", {31'd0, data_req_o}, 32'd0);
        check("wrst_allow", {31'd0, ms_allowin_o}, 32'd1);
        check("wrst_wb", {22'd0, wb_ctrl_o}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        data_data_ok_i = 1'b1;
        @(negedge clk);
        data_data_ok_i = 1'b0;
        check("wrst_nowb", {22'd0, wb_ctrl_o}, 32'd0);
        check("wrst_noreq", {31'd0, data_req_o}, 32'd0);

        for (int i = 0; i < 60; i++) begin
            logic [2:0] t;
            logic [1:0] mop;
            t = 3'($urandom % 5);
            mop = 2'($urandom % 3);
            run($urandom, {t, mop == 2'd2, mop == 2'd1}, 10'($urandom) | 10'd1, $urandom, $urandom,
                5'($urandom), $urandom, int'($urandom % 5), 1 + int'($urandom % 3), ($urandom % 4) == 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
